// File: rtl/tdm_demux_1x16_pkg.sv
// Shared constants for the 16-slot TDM receive demultiplexer.
package tdm_demux_1x16_pkg;

    // Slots per TDM frame and the width of a slot index.
    localparam int NSLOT  = 16;
    localparam int SLOT_W = 4;

endpackage : tdm_demux_1x16_pkg

// File: rtl/tdm_demux_1x16_demux_1x4.sv
// One-hot 1:4 write-enable decoder; two levels of these form the 4-to-16
// slot decode, mirroring the 4:1 mux tree on the transmit side.
module demux_1x4 (
    input  logic       en_i,
    input  logic [1:0] sel_i,
    output logic [3:0] y_o
);

    // Route the enable to exactly one output, or none when disabled.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule : demux_1x4

// File: rtl/tdm_demux_1x16.sv
// 16-slot TDM receive demultiplexer. Samples are gathered into a working
// bank and the full 16-channel output bank is loaded atomically when the
// slot-15 sample arrives, so downstream logic never sees a mixed frame.
module tdm_demux_1x16
    import tdm_demux_1x16_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    input  logic                     frame_start,
    output logic [NSLOT*WIDTH-1:0]   out,
    output logic                     frame_valid,
    output logic                     sync_err,
    output logic [SLOT_W-1:0]        slot,
    output logic                     locked
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic                         locked_q, locked_d;
    logic                         frame_valid_q, frame_valid_d;
    logic                         sync_err_q, sync_err_d;
    logic [NSLOT*WIDTH-1:0]       out_q;

    // Slots 0..14 are staged here; slot 15 goes straight into the output bank.
    logic [WIDTH-1:0]             working_q [NSLOT-1];
    logic [(NSLOT-1)*WIDTH-1:0]   working_flat;

    // Write request: which slot the current beat lands in, if any.
    logic                         wr_en;
    logic [SLOT_W-1:0]            wr_slot;
    logic [3:0]                   grp_en;
    logic [NSLOT-1:0]             slot_we;

    // Next-state decode for slot counter, lock state, strobes and write request.
    always_comb begin
        slot_d        = slot_q;
        locked_d      = locked_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        wr_en         = 1'b0;
        wr_slot       = slot_q;
        if (din_valid) begin
            if (frame_start) begin
                // A marker always restarts at slot 0; mid-frame it is an error
                // and whatever partial frame was gathered is abandoned.
                sync_err_d = locked_q && (slot_q != '0);
                slot_d     = SLOT_W'(1);
                locked_d   = 1'b1;
                wr_en      = 1'b1;
                wr_slot    = '0;
            end else if (locked_q) begin
                if (slot_q == '0) begin
                    // Slot 0 must carry a marker; lose lock and drop the sample.
                    sync_err_d = 1'b1;
                    locked_d   = 1'b0;
                end else if (slot_q == LAST_SLOT) begin
                    frame_valid_d = 1'b1;
                    slot_d        = '0;
                    wr_en         = 1'b1;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                    wr_en  = 1'b1;
                end
            end
        end
    end

    // Two-level one-hot decode: upper slot bits pick a group of four,
    // lower bits pick the slot inside the group.
    demux_1x4 u_grp_dec (
        .en_i  (wr_en),
        .sel_i (wr_slot[3:2]),
        .y_o   (grp_en)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_leaf_dec
            demux_1x4 u_leaf_dec (
                .en_i  (grp_en[gi]),
                .sel_i (wr_slot[1:0]),
                .y_o   (slot_we[gi*4 +: 4])
            );
        end
    endgenerate

    // Working bank registers, one per staged slot, loaded on their write enable.
    generate
        for (genvar gi = 0; gi < NSLOT - 1; gi++) begin : g_working
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    working_q[gi] <= '0;
                end else if (slot_we[gi]) begin
                    working_q[gi] <= din;
                end
            end
            assign working_flat[gi*WIDTH +: WIDTH] = working_q[gi];
        end
    endgenerate

    // Control state, strobes and the atomic output bank load on frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            out_q         <= '0;
        end else begin
            slot_q        <= slot_d;
            locked_q      <= locked_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            if (slot_we[NSLOT-1]) begin
                out_q <= {din, working_flat};
            end
        end
    end

    assign out         = out_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = locked_q;

endmodule : tdm_demux_1x16

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for the 16-slot TDM demultiplexer.
module tb_tdm_demux_1x16;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_start;
    logic [16*W-1:0] out;
    logic           frame_valid;
    logic           sync_err;
    logic [3:0]     slot;
    logic           locked;

    int n_cmp;
    int n_bad;
    int fv_cnt;
    int se_cnt;

    tdm_demux_1x16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .out         (out),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .slot        (slot),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One clock of stimulus; outputs are observed 1 ns after the edge.
    task automatic step(input logic v, input logic fs, input logic [W-1:0] d);
        din         = d;
        din_valid   = v;
        frame_start = fs;
        @(posedge clk);
        #1;
        if (frame_valid) fv_cnt++;
        if (sync_err)    se_cnt++;
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    function automatic logic [127:0] frame_of(input logic [W-1:0] base);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 16; c++) begin
            r[c*W +: W] = base + W'(c);
        end
        return r;
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0; fv_cnt = 0; se_cnt = 0;
        rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;
        #12;
        check("reset_out",    out, '0);
        check("reset_slot",   slot, 0);
        check("reset_locked", locked, 0);
        check("reset_fv",     frame_valid, 0);
        check("reset_se",     sync_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Missing marker from reset: everything dropped.
        for (int c = 0; c < 16; c++) step(1'b1, 1'b0, W'(c + 8'h40));
        check("nomark_locked", locked, 0);
        check("nomark_slot",   slot, 0);
        check("nomark_fv_cnt", fv_cnt, 0);
        check("nomark_se_cnt", se_cnt, 0);
        check("nomark_out",    out, '0);

        // Unlocked noise: marker without valid does nothing.
        step(1'b0, 1'b1, 8'h55);
        check("noise_locked", locked, 0);
        check("noise_slot",   slot, 0);

        // Nominal frame 0x00..0x0F.
        step(1'b1, 1'b1, 8'h00);
        check("start_locked", locked, 1);
        check("start_slot",   slot, 1);
        for (int c = 1; c < 16; c++) begin
            step(1'b1, 1'b0, W'(c));
            if (c == 14) check("pre_last_fv", frame_valid, 0);
        end
        check("nom_fv",   frame_valid, 1);
        check("nom_out",  out, frame_of(8'h00));
        check("nom_slot", slot, 0);
        check("nom_se",   sync_err, 0);
        step(1'b0, 1'b0, 8'h00);
        check("nom_fv_pulse", frame_valid, 0);
        check("nom_fv_cnt",   fv_cnt, 1);

        // Gapped repeat of the same frame.
        fv_cnt = 0;
        step(1'b1, 1'b1, 8'h00);
        for (int c = 1; c < 16; c++) begin
            if (c % 3 == 0) step(1'b0, 1'b1, 8'hAA);
            if (c % 5 == 0) step(1'b0, 1'b0, 8'hBB);
            step(1'b1, 1'b0, W'(c));
        end
        check("gap_fv",   frame_valid, 1);
        check("gap_out",  out, frame_of(8'h00));
        // Back-to-back second frame 0xF0+c, no idle cycle.
        step(1'b1, 1'b1, 8'hF0);
        check("b2b_fv_clear", frame_valid, 0);
        for (int c = 1; c < 16; c++) step(1'b1, 1'b0, W'(8'hF0 + c));
        check("b2b_fv",   frame_valid, 1);
        check("b2b_out",  out, frame_of(8'hF0));
        check("b2b_fv_cnt", fv_cnt, 2);

        // Early marker at slot 7.
        fv_cnt = 0; se_cnt = 0;
        step(1'b1, 1'b1, 8'h20);
        for (int c = 1; c < 7; c++) step(1'b1, 1'b0, W'(8'h20 + c));
        check("early_pre_slot", slot, 7);
        step(1'b1, 1'b1, 8'h30);
        check("early_se",     sync_err, 1);
        check("early_fv",     frame_valid, 0);
        check("early_out",    out, frame_of(8'hF0));
        check("early_slot",   slot, 1);
        check("early_locked", locked, 1);
        for (int c = 1; c < 16; c++) step(1'b1, 1'b0, W'(8'h30 + c));
        check("early_new_fv",  frame_valid, 1);
        check("early_new_out", out, frame_of(8'h30));
        check("early_fv_cnt",  fv_cnt, 1);
        check("early_se_cnt",  se_cnt, 1);

        // Missing marker after a completed frame.
        step(1'b1, 1'b0, 8'h99);
        check("miss_se",     sync_err, 1);
        check("miss_fv",     frame_valid, 0);
        check("miss_locked", locked, 0);
        check("miss_slot",   slot, 0);
        check("miss_out",    out, frame_of(8'h30));

        // Asynchronous reset mid-frame.
        step(1'b1, 1'b1, 8'h60);
        step(1'b1, 1'b0, 8'h61);
        check("mid_slot", slot, 2);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out",    out, '0);
        check("arst_slot",   slot, 0);
        check("arst_locked", locked, 0);
        check("arst_fv",     frame_valid, 0);
        check("arst_se",     sync_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Reacquire: a full frame after reset yields only new data.
        fv_cnt = 0;
        step(1'b1, 1'b1, 8'h70);
        for (int c = 1; c < 16; c++) step(1'b1, 1'b0, W'(8'h70 + c));
        check("reacq_out",    out, frame_of(8'h70));
        check("reacq_fv_cnt", fv_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tdm_demux_1x16
